// File: rtl/jtframe_dwnld_pack.sv
// Packs the ioctl byte stream into masked DW-bit words behind a small FIFO.
// Optional byte checksum on csum when JTFRAME_DWNLD_CSUM_EN is defined.
module jtframe_dwnld_pack #(
    parameter int DW       = 16,
    parameter int AW       = 25,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4
) (
    input  logic                         clk_rom,
    input  logic                         rst_n,
    input  logic                         downloading,
    input  logic [7:0]                   ioctl_index,
    input  logic [AW-1:0]                ioctl_addr,
    input  logic [7:0]                   ioctl_data,
    input  logic                         ioctl_wr,
    output logic [AW-$clog2(DW/8)-1:0]   prog_addr,
    output logic [DW-1:0]                prog_data,
    output logic [DW/8-1:0]              prog_mask,
    output logic [1:0]                   prog_ch,
    output logic                         prog_we,
    input  logic                         prog_rdy,
    output logic                         done,
    output logic                         overflow,
    output logic [15:0]                  csum
);
    localparam int NB  = DW / 8;
    localparam int LW  = $clog2(NB);
    localparam int LWX = (LW > 0) ? LW : 1;
    localparam int WAW = AW - LW;
    localparam int PW  = $clog2(DEPTH);
    localparam int WW  = 2 + NB + DW + WAW;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_FLUSH} state_t;

    state_t         state_q, state_d;
    logic [DW-1:0]  bdata_q, bdata_d;
    logic [NB-1:0]  bmask_q, bmask_d;
    logic [WAW-1:0] baddr_q, baddr_d;
    logic [1:0]     bch_q, bch_d;
    logic           dl_q;
    logic           armed_q, armed_d;
    logic           ovf_q, ovf_d;
    logic           rise;
    logic           accept;
    logic           push;
    logic [WW-1:0]  pword;

    logic [WAW-1:0] in_addr;
    logic [1:0]     in_ch;
    logic [LWX-1:0] lane;
    logic [NB-1:0]  lane_bit;

    logic [WW-1:0]  mem [DEPTH];
    logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]    cnt_q, cnt_d, total;
    logic           full, xfer, load, push_ok;
    logic           we_d;
    logic [WW-1:0]  oword_q, oword_d;

    always_comb begin
        in_addr  = ioctl_addr[AW-1:LW];
        lane     = (LW == 0) ? '0 : ioctl_addr[LWX-1:0];
        lane_bit = NB'(1) << lane;
        in_ch    = (ioctl_index >= 8'(CHANNELS-1)) ? 2'(CHANNELS-1)
                                                   : ioctl_index[1:0];
        rise     = downloading & ~dl_q;
        accept   = (state_q == S_FILL) & downloading & ioctl_wr;
    end

    always_comb begin
        state_d = state_q;
        bdata_d = bdata_q;
        bmask_d = bmask_q;
        baddr_d = baddr_q;
        bch_d   = bch_q;
        push    = 1'b0;
        pword   = {bch_q, bmask_q, bdata_q, baddr_q};
        unique case (state_q)
            S_IDLE: begin
                if (downloading) begin
                    state_d = S_FILL;
                    bdata_d = '0;
                    bmask_d = '0;
                end
            end
            S_FILL: begin
                if (!downloading) begin
                    state_d = (bmask_q != '0) ? S_FLUSH : S_IDLE;
                end else if (ioctl_wr) begin
                    // A byte for another word or channel retires the partial one
                    if (bmask_q != '0 &&
                        (in_addr != baddr_q || in_ch != bch_q)) begin
                        push    = 1'b1;
                        bdata_d = '0;
                        bmask_d = '0;
                    end
                    bdata_d[{lane, 3'b000} +: 8] = ioctl_data;
                    bmask_d = bmask_d | lane_bit;
                    baddr_d = in_addr;
                    bch_d   = in_ch;
                    if (&bmask_d) begin
                        push    = 1'b1;
                        pword   = {bch_d, bmask_d, bdata_d, baddr_d};
                        bdata_d = '0;
                        bmask_d = '0;
                    end
                end
            end
            S_FLUSH: begin
                push    = 1'b1;
                bdata_d = '0;
                bmask_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Occupancy counts the output register so DEPTH words fit in total
    always_comb begin
        total   = cnt_q + {{PW{1'b0}}, prog_we};
        full    = (total == (PW+1)'(DEPTH));
        xfer    = prog_we & prog_rdy;
        push_ok = push & (~full | xfer);
        load    = (cnt_q != '0) & (~prog_we | prog_rdy);
        cnt_d   = cnt_q + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, load};
        wr_d    = wr_q + PW'(push_ok);
        rd_d    = rd_q + PW'(load);
        we_d    = prog_we & ~prog_rdy;
        oword_d = oword_q;
        if (load) begin
            we_d    = 1'b1;
            oword_d = mem[rd_q];
        end
        ovf_d = rise ? 1'b0 : ovf_q;
        if (push & ~push_ok) ovf_d = 1'b1;
    end

    assign done = armed_q & ~downloading & (state_q == S_IDLE) &
                  (bmask_q == '0) & (cnt_q == '0) & ~prog_we;

    always_comb begin
        armed_d = armed_q;
        if (done) armed_d = 1'b0;
        if (rise) armed_d = 1'b1;
    end

    always_ff @(posedge clk_rom) begin
        if (push_ok) mem[wr_q] <= pword;
    end

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bdata_q <= '0;
            bmask_q <= '0;
            baddr_q <= '0;
            bch_q   <= '0;
            dl_q    <= 1'b0;
            armed_q <= 1'b0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            prog_we <= 1'b0;
            oword_q <= '0;
        end else begin
            state_q <= state_d;
            bdata_q <= bdata_d;
            bmask_q <= bmask_d;
            baddr_q <= baddr_d;
            bch_q   <= bch_d;
            dl_q    <= downloading;
            armed_q <= armed_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            prog_we <= we_d;
            oword_q <= oword_d;
        end
    end

    assign prog_addr = oword_q[WAW-1:0];
    assign prog_data = oword_q[WAW +: DW];
    assign prog_mask = oword_q[WAW+DW +: NB];
    assign prog_ch   = oword_q[WW-1 -: 2];
    assign overflow  = ovf_q;

`ifdef JTFRAME_DWNLD_CSUM_EN
    logic [15:0] csum_q, csum_d;

    always_comb begin
        csum_d = rise ? 16'd0 : csum_q;
        if (accept) csum_d = csum_d + {8'd0, ioctl_data};
    end

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) csum_q <= '0;
        else        csum_q <= csum_d;
    end

    assign csum = csum_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign csum = '0;
`endif

endmodule

// File: doc/jtframe_dwnld_pack.md
# jtframe_dwnld_pack

Parametrised download packer between `data_io` byte output and the SDRAM/BRAM programming port. It assembles the 8-bit `ioctl` stream into DW-bit words with byte masks and routes them by `ioctl_index` channel. A small FIFO with a valid/ready handshake buffers the words, so a slow memory controller never loses ROM data. It runs in the ROM clock domain.

## Interface
Parameters:
- DW, 16: output word width; 8, 16 or 32.
- AW, 25: byte address width of `ioctl_addr`.
- CHANNELS, 2: number of distinct download channels, 1..4.
- DEPTH, 4: FIFO depth in words; power of two, 2..16.

Ports:
- clk_rom  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- downloading  in  1  download active, from `data_io`.
- ioctl_index  in  8  file index.
- ioctl_addr  in  AW  byte address.
- ioctl_data  in  8  byte data.
- ioctl_wr  in  1  one-cycle byte strobe.
- prog_addr  out  AW-log2(DW/8)  word address.
- prog_data  out  DW  word data, little-endian lanes.
- prog_mask  out  DW/8  lane valid mask, bit i = byte i.
- prog_ch  out  2  channel: `min(ioctl_index, CHANNELS-1)`.
- prog_we  out  1  word valid; held until accepted.
- prog_rdy  in  1  consumer ready; transfer occurs when `prog_we & prog_rdy`.
- done  out  1  one-cycle pulse when the download has fully drained.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.
- csum  out  16  byte checksum (see Configuration).

## Operation
- Assembler state machine has three states:
  - IDLE: waits for `downloading`.
  - FILL: accumulates bytes.
  - FLUSH: pushes a partial word, then returns to IDLE.
- `downloading` rising edge: clears the lane buffer, mask, `overflow` and `csum`. Words already queued are not discarded.
- Byte accept when `ioctl_wr` is high in FILL:
  - Byte goes to lane `ioctl_addr[log2(DW/8)-1:0]`; that lane's mask bit is set.
  - Current word address = `ioctl_addr >> log2(DW/8)`.
- Push conditions, in priority order:
  1. Incoming byte has a different word address or channel than the buffered partial word: push the buffered word first, then start a new buffer with the incoming byte. Both happen in the same cycle.
  2. Mask becomes all ones: push.
  3. `downloading` falls with a non-empty mask: go to FLUSH and push.
- DW=8: every byte pushes directly.
- FIFO full on push: word dropped and `overflow` set to 1. It stays 1 until reset or the next download start.
- Simultaneous push and pop on a full FIFO: the push succeeds.
- `done` pulses once when all of the following hold: `downloading` is low, the assembler is IDLE with an empty mask, the FIFO is empty, and no transfer is pending.
- Reset mid-operation: all state is discarded immediately, with no flush.

## Timing
- Reset values:
  - `prog_we`, `done`, `overflow`: 0.
  - `prog_addr`, `prog_data`, `prog_mask`, `prog_ch`, `csum`: 0.
- Latency: the word is written into the FIFO on the edge after the completing `ioctl_wr`. `prog_we` is high on the following cycle, so it rises 2 cycles after the strobe cycle when the FIFO was empty.
- Output handshake:
  - `prog_*` are registered and stable while `prog_we & ~prog_rdy`.
  - After an accepted transfer, the next word is presented the next cycle with no bubble.
- `done` is asserted 1 cycle after the last pop.
- Minimum `ioctl_wr` spacing: 1 cycle. Back-to-back bytes are accepted without loss unless the FIFO is full.

## Configuration
- Macro: JTFRAME_DWNLD_CSUM_EN.
- Defined:
  - `csum` is a 16-bit wrap-around sum of every accepted byte, zero-extended.
  - It is cleared on the `downloading` rising edge and valid from 1 cycle after each byte.
  - It holds its value after the download ends.
- Undefined: `csum` is tied to 0 and no adder is synthesised.

## Test plan
- DW=16: write 0x11@0 then 0x22@1 → `prog_we` 2 cycles after the second strobe, with `prog_addr`=0, `prog_data`=0x2211, `prog_mask`=2'b11, `prog_ch`=0.
- DW=16: write 0x33@5, then drop `downloading` → word with `prog_addr`=2, `prog_data[15:8]`=0x33, `prog_mask`=2'b10; `done` pulses 1 cycle after the pop.
- DW=32, `prog_rdy`=0, DEPTH=4: send 5 full words → FIFO holds the first 4 and `overflow`=1. With `prog_rdy`=1 afterwards, exactly 4 words drain in order.
- CHANNELS=2: byte with `ioctl_index`=0 at addr 0, then `ioctl_index`=5 at addr 1 → two partial words: ch 0 mask 2'b01, and ch 1 mask 2'b10.
- With JTFRAME_DWNLD_CSUM_EN: stream 0xFF×300 → `csum`=0x2AD4. Without the macro, `csum`=0.
- Assert `rst_n`=0 mid-word, then release → all outputs are 0, no word is emitted, and `done` does not pulse.
